tri_scom_req_ctrl: RTL and testbench
====================================

TRI_SCOM_REQ_CTRL -- requirements
Module: tri_scom_req_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 64: number of decodable SCOM register slots.
REQ-002 SHALL have parameter SATID_NOBITS, default 5: satellite-ID bits; address width is 11-SATID_NOBITS.
REQ-003 SHALL have parameters USE_ADDR, ADDR_IS_RDABLE, ADDR_IS_WRABLE, each [0:ADDR_SIZE-1], default bit 0 set only: implemented, readable and writable slot masks.
REQ-004 SHALL have parameter TIMEOUT, default 15: WAIT cycles allowed before abort, legal range 1..255.
REQ-005 SHALL have ports: nclk in 1 clock; rst in 1 reset.
REQ-006 SHALL have ports: sc_req in 1 request pulse; sc_addr in [0:11-SATID_NOBITS-1] binary address; sc_r_nw in 1 read/not-write; sc_wdata in [0:63] write data; sc_wdata_par in 1 even parity of sc_wdata.
REQ-007 SHALL have ports: sc_busy out 1 request in flight; sc_ack out 1 completion pulse; sc_ack_info out [0:1] status, bit0 access error, bit1 timeout; sc_rdata out [0:63] read data.
REQ-008 SHALL have ports: reg_wr_en out [0:ADDR_SIZE-1] one-hot write strobe; reg_rd_en out [0:ADDR_SIZE-1] one-hot read strobe; reg_wdata out [0:63]; reg_ack in 1 register done; reg_rdata in [0:63].
REQ-009 SHALL use one clock, nclk; reset rst is synchronous and active-high.

Function
REQ-010 SHALL implement FSM IDLE, ACCESS, WAIT, RESP; sc_busy=1 in every state except IDLE.
REQ-011 In IDLE with sc_req=1, SHALL capture sc_addr, sc_r_nw, sc_wdata into registers and go to ACCESS.
REQ-012 SHALL ignore sc_req while not IDLE; no queuing.
REQ-013 In ACCESS, SHALL decode the captured address: slot i hits when address==i and USE_ADDR[i]=1; addresses >= ADDR_SIZE hit nothing.
REQ-014 In ACCESS, with no hit, or a write to a slot without ADDR_IS_WRABLE, or a read from a slot without ADDR_IS_RDABLE, SHALL go to RESP with sc_ack_info=2'b10 (bit0 set) and SHALL assert no strobe.
REQ-015 In ACCESS, for a legal access, SHALL assert exactly one bit of reg_wr_en (write) or reg_rd_en (read) for exactly one cycle, drive reg_wdata=captured data, and go to WAIT.
REQ-016 reg_wdata SHALL hold the captured data from ACCESS until leaving WAIT; it is zero otherwise.
REQ-017 In WAIT, reg_ack=1 SHALL go to RESP with sc_ack_info=2'b00; for reads, reg_rdata SHALL be captured into sc_rdata on that cycle.
REQ-018 reg_ack SHALL be ignored in IDLE, ACCESS and RESP.
REQ-019 An 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle; if the TIMEOUT-th WAIT cycle ends without reg_ack, SHALL go to RESP with sc_ack_info=2'b01 (bit1 set).
REQ-020 reg_ack on the same cycle as timeout expiry SHALL win: normal completion, no timeout.
REQ-021 In RESP, SHALL assert sc_ack for one cycle with sc_ack_info and sc_rdata valid, then go to IDLE.
REQ-022 sc_rdata SHALL be zero on writes, errors and timeouts, and SHALL hold its value until the next request is captured.
REQ-023 Minimum latency SHALL be: request accepted cycle 0, strobe cycle 1, reg_ack cycle 2, sc_ack cycle 3; error response sc_ack on cycle 2.

Reset
REQ-024 On rst=1 at a clock edge, FSM SHALL go to IDLE and the counter and all capture registers SHALL clear.
REQ-025 Reset values SHALL be sc_busy=0, sc_ack=0, sc_ack_info=0, sc_rdata=0, reg_wr_en=0, reg_rd_en=0, reg_wdata=0.
REQ-026 Reset mid-transaction SHALL abort it without producing sc_ack; a reg_ack after reset SHALL be ignored.

Configuration
REQ-027 With macro TRI_SCOM_WDATA_PARITY_EN defined, a write request whose sc_wdata parity mismatches sc_wdata_par SHALL be treated as an access error in ACCESS (no strobe, sc_ack_info=2'b10).
REQ-028 Without TRI_SCOM_WDATA_PARITY_EN, sc_wdata_par SHALL be ignored; reads are never parity-checked in either build.

Verification
REQ-029 Write addr 0 with wdata 64'h0123456789ABCDEF, default masks, reg_ack on cycle 2 -> reg_wr_en[0] high on cycle 1 only; sc_ack on cycle 3; info 00; sc_rdata 0.
REQ-030 Read addr 0 with reg_ack on the 3rd WAIT cycle and reg_rdata=64'hDEADBEEF00000001 -> sc_ack 1 cycle later; sc_rdata=64'hDEADBEEF00000001; info 00.
REQ-031 Read addr 5 with USE_ADDR bit 5 clear, and a write to a slot whose ADDR_IS_WRABLE bit is 0 -> no strobe; sc_ack on cycle 2; info 10.
REQ-032 Read addr 0 with reg_ack never asserted, TIMEOUT=15 -> sc_ack after 15 WAIT cycles with info 01; rerun with reg_ack on WAIT cycle 15 -> info 00.
REQ-033 Second sc_req during WAIT, then rst pulse mid-WAIT -> second request ignored; after rst, sc_busy=0 and no sc_ack.
REQ-034 Write with wrong sc_wdata_par -> with TRI_SCOM_WDATA_PARITY_EN: info 10, no strobe; without it: normal write, info 00.

Source files
------------

// File: rtl/tri_scom_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tri_scom_req_ctrl
//  Purpose  : SCOM satellite request controller. It accepts one request at a
//             time, decodes the address to a one-hot register strobe, waits
//             for the register acknowledge with a bounded timeout, and returns
//             a one-cycle acknowledge with status and read data.
//  Options  : TRI_SCOM_WDATA_PARITY_EN - when defined, a write whose data
//             fails the even-parity check is rejected as an access error.
//  Revision : 1.0 - initial release
// ============================================================================
module tri_scom_req_ctrl #(
  parameter int                   ADDR_SIZE      = 64,
  parameter int                   SATID_NOBITS   = 5,
  parameter logic [0:ADDR_SIZE-1] USE_ADDR       = {1'b1, {(ADDR_SIZE-1){1'b0}}},
  parameter logic [0:ADDR_SIZE-1] ADDR_IS_RDABLE = {1'b1, {(ADDR_SIZE-1){1'b0}}},
  parameter logic [0:ADDR_SIZE-1] ADDR_IS_WRABLE = {1'b1, {(ADDR_SIZE-1){1'b0}}},
  parameter int                   TIMEOUT        = 15
) (
  input  logic                        nclk,
  input  logic                        rst,
  input  logic                        sc_req,
  input  logic [0:11-SATID_NOBITS-1]  sc_addr,
  input  logic                        sc_r_nw,
  input  logic [0:63]                 sc_wdata,
  input  logic                        sc_wdata_par,
  output logic                        sc_busy,
  output logic                        sc_ack,
  output logic [0:1]                  sc_ack_info,
  output logic [0:63]                 sc_rdata,
  output logic [0:ADDR_SIZE-1]        reg_wr_en,
  output logic [0:ADDR_SIZE-1]        reg_rd_en,
  output logic [0:63]                 reg_wdata,
  input  logic                        reg_ack,
  input  logic [0:63]                 reg_rdata
);

  localparam int         c_aw       = 11 - SATID_NOBITS;
  // Counter value seen during the last WAIT cycle allowed before abort.
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [0:c_aw-1]  addr_q,  addr_d;
  logic             r_nw_q,  r_nw_d;
  logic [0:63]      wdata_q, wdata_d;
  logic [0:63]      rdata_q, rdata_d;
  logic [0:1]       info_q,  info_d;
  logic [7:0]       cnt_q,   cnt_d;

  logic [31:0]          addr_idx;
  logic [0:ADDR_SIZE-1] dec;
  logic [0:ADDR_SIZE-1] hit_vec;
  logic                 par_err;
  logic                 access_ok;

`ifdef TRI_SCOM_WDATA_PARITY_EN
  // Parity verdict is taken at capture time, against the data actually captured.
  logic par_err_q, par_err_d;
  assign par_err = par_err_q;
`else
  // Parity input has no effect in this build.
  logic unused_par;
  assign unused_par = sc_wdata_par;
  assign par_err    = 1'b0;
`endif

  // Address decode: addresses past the last slot simply match no decoder line.
  assign addr_idx = 32'(addr_q);

  for (genvar i = 0; i < ADDR_SIZE; i++) begin : g_dec
    assign dec[i] = (addr_idx == i);
  end

  assign hit_vec = dec & USE_ADDR;

  // Legal access check: implemented slot with matching permission, good parity.
  always_comb begin
    access_ok = 1'b0;
    if (r_nw_q) begin
      access_ok = |(hit_vec & ADDR_IS_RDABLE);
    end else begin
      access_ok = (|(hit_vec & ADDR_IS_WRABLE)) & ~par_err;
    end
  end

  // Next-state and capture logic for the request FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    r_nw_d  = r_nw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    info_d  = info_q;
    cnt_d   = cnt_q;
`ifdef TRI_SCOM_WDATA_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (sc_req) begin
          state_d = ACCESS;
          addr_d  = sc_addr;
          r_nw_d  = sc_r_nw;
          wdata_d = sc_wdata;
          rdata_d = '0;
          info_d  = 2'b00;
`ifdef TRI_SCOM_WDATA_PARITY_EN
          par_err_d = ~sc_r_nw & ((^sc_wdata) ^ sc_wdata_par);
`endif
        end
      end
      ACCESS: begin
        if (access_ok) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
        end else begin
          state_d = RESP;
          info_d  = 2'b10;
        end
      end
      WAIT: begin
        // An acknowledge in the final allowed cycle beats the timeout.
        if (reg_ack) begin
          state_d = RESP;
          info_d  = 2'b00;
          if (r_nw_q) begin
            rdata_d = reg_rdata;
          end
        end else if (cnt_q == c_tmo_last) begin
          state_d = RESP;
          info_d  = 2'b01;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge nclk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      r_nw_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      info_q  <= 2'b00;
      cnt_q   <= 8'd0;
`ifdef TRI_SCOM_WDATA_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      r_nw_q  <= r_nw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      info_q  <= info_d;
      cnt_q   <= cnt_d;
`ifdef TRI_SCOM_WDATA_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Outputs are decoded from registered state only.
  assign sc_busy     = (state_q != IDLE);
  assign sc_ack      = (state_q == RESP);
  assign sc_ack_info = (state_q == RESP) ? info_q : 2'b00;
  assign sc_rdata    = rdata_q;
  assign reg_wr_en   = (state_q == ACCESS && access_ok && !r_nw_q) ? hit_vec : '0;
  assign reg_rd_en   = (state_q == ACCESS && access_ok &&  r_nw_q) ? hit_vec : '0;
  assign reg_wdata   = (state_q == ACCESS || state_q == WAIT) ? wdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_tri_scom_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tri_scom_req_ctrl
//  Purpose  : Self-checking bench for tri_scom_req_ctrl: directed vector
//             table, hand-written reset sequences and randomized traffic
//             against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tri_scom_req_ctrl;

  localparam int          c_slots = 48;
  localparam int          c_tmo   = 15;
  // Implemented slots 0,1,2,3,10,33; readable 0,1,3,10; writable 0,2,3,33.
  localparam logic [0:47] c_use   = 48'hF020_0000_4000;
  localparam logic [0:47] c_rd    = 48'hD020_0000_0000;
  localparam logic [0:47] c_wr    = 48'hB000_0000_4000;

  logic        nclk = 1'b0;
  logic        rst;
  logic        sc_req;
  logic [0:5]  sc_addr;
  logic        sc_r_nw;
  logic [0:63] sc_wdata;
  logic        sc_wdata_par;
  logic        sc_busy;
  logic        sc_ack;
  logic [0:1]  sc_ack_info;
  logic [0:63] sc_rdata;
  logic [0:47] reg_wr_en;
  logic [0:47] reg_rd_en;
  logic [0:63] reg_wdata;
  logic        reg_ack;
  logic [0:63] reg_rdata;

  int n_chk = 0;
  int n_err = 0;
  int txn_id = 0;
  int cyc_g = 0;

  tri_scom_req_ctrl #(
    .ADDR_SIZE(c_slots), .SATID_NOBITS(5), .USE_ADDR(c_use),
    .ADDR_IS_RDABLE(c_rd), .ADDR_IS_WRABLE(c_wr), .TIMEOUT(c_tmo)
  ) dut (
    .nclk(nclk), .rst(rst), .sc_req(sc_req), .sc_addr(sc_addr), .sc_r_nw(sc_r_nw),
    .sc_wdata(sc_wdata), .sc_wdata_par(sc_wdata_par), .sc_busy(sc_busy), .sc_ack(sc_ack),
    .sc_ack_info(sc_ack_info), .sc_rdata(sc_rdata), .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en), .reg_wdata(reg_wdata), .reg_ack(reg_ack), .reg_rdata(reg_rdata)
  );

  always #5 nclk = ~nclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (txn %0d cyc %0d): got %h expected %h", nm, txn_id, cyc_g, act, exp);
    end
  endtask

  function automatic bit par_of(input logic [63:0] d);
    return ^d;
  endfunction

  // Transaction-level reference: outcome, ack cycle, status and data.
  function automatic void model(input int addr, input bit r_nw, input logic [63:0] wd,
                                input bit par, input int ack_wc, input logic [63:0] rd,
                                output int lat, output logic [1:0] info,
                                output logic [63:0] exp_rd, output bit ok);
    ok = (addr < c_slots) && c_use[addr] && (r_nw ? c_rd[addr] : c_wr[addr]);
`ifdef TRI_SCOM_WDATA_PARITY_EN
    if (!r_nw && (par_of(wd) != par)) ok = 1'b0;
`endif
    if (!ok) begin
      lat = 2; info = 2'b10; exp_rd = '0;
    end else if (ack_wc >= 1 && ack_wc <= c_tmo) begin
      lat = ack_wc + 2; info = 2'b00; exp_rd = r_nw ? rd : 64'd0;
    end else begin
      lat = c_tmo + 2; info = 2'b01; exp_rd = '0;
    end
  endfunction

  // Issue one request at the current negedge and check every cycle through
  // the acknowledge and the following idle cycle. ack_wc is the WAIT cycle
  // (1-based) on which reg_ack is driven; 0 means never.
  task automatic run_txn(input int addr, input bit r_nw, input logic [63:0] wd, input bit par,
                         input int ack_wc, input logic [63:0] rd, input int lat,
                         input logic [1:0] info, input logic [63:0] exp_rd, input bit ok,
                         input bit noise);
    logic [0:47] oh;
    logic [0:47] exp_wr;
    logic [0:47] exp_rdstb;
    bit          ack_here;
    bit          nonwait;
    oh = '0;
    if (addr < c_slots) oh[addr] = 1'b1;
    txn_id++;
    sc_req = 1'b1; sc_addr = 6'(addr); sc_r_nw = r_nw; sc_wdata = wd;
    sc_wdata_par = par; reg_ack = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge nclk);
      cyc_g = c;
      exp_wr    = (ok && !r_nw && c == 1) ? oh : '0;
      exp_rdstb = (ok &&  r_nw && c == 1) ? oh : '0;
      chk("busy", 64'(sc_busy), 64'(c <= lat));
      chk("sc_ack", 64'(sc_ack), 64'(c == lat));
      chk("reg_wr_en", 64'(reg_wr_en), 64'(exp_wr));
      chk("reg_rd_en", 64'(reg_rd_en), 64'(exp_rdstb));
      if (ok || c >= lat) chk("reg_wdata", reg_wdata, (ok && c < lat) ? wd : 64'd0);
      if (c == lat) chk("ack_info", 64'({sc_ack_info[0], sc_ack_info[1]}), 64'(info));
      chk("sc_rdata", sc_rdata, (c >= lat) ? exp_rd : 64'd0);
      if (c == lat + 1) begin
        sc_req = 1'b0; reg_ack = 1'b0;
      end else begin
        ack_here = (ack_wc > 0) && (c == ack_wc + 1);
        nonwait  = (c == 1) || (c >= lat) || !ok;
        reg_ack   = ack_here | (noise && nonwait && ($urandom_range(0, 1) == 1));
        reg_rdata = ack_here ? rd : {$urandom, $urandom};
        sc_req    = noise && ($urandom_range(0, 1) == 1);
        if (noise) begin
          sc_addr = 6'($urandom_range(0, 63)); sc_r_nw = 1'($urandom);
          sc_wdata = {$urandom, $urandom};
        end
      end
    end
  endtask

  typedef struct {
    int          addr;
    bit          r_nw;
    logic [63:0] wd;
    bit          par;
    int          ack_wc;
    logic [63:0] rd;
    int          lat;
    logic [1:0]  info;
    logic [63:0] exp_rd;
    bit          ok;
  } vec_t;

  vec_t tbl[14];
  int   hot[6] = '{0, 1, 2, 3, 10, 33};

  initial begin
    logic [63:0] wd;
    logic [63:0] rd;
    int          lat;
    logic [1:0]  info;
    logic [63:0] exp_rd;
    bit          ok;
    int          addr;
    bit          r_nw;
    bit          par;
    int          ack_wc;
    int          gap;

    tbl[0]  = '{0,  1'b0, 64'h0123456789ABCDEF, par_of(64'h0123456789ABCDEF), 1,
                64'h5555, 3, 2'b00, 64'd0, 1'b1};
    tbl[1]  = '{0,  1'b1, 64'h1111, 1'b0, 3, 64'hDEADBEEF00000001, 5, 2'b00,
                64'hDEADBEEF00000001, 1'b1};
    tbl[2]  = '{5,  1'b1, 64'h2222, 1'b0, 1, 64'h99, 2, 2'b10, 64'd0, 1'b0};
    tbl[3]  = '{1,  1'b0, 64'h3333, par_of(64'h3333), 1, 64'h98, 2, 2'b10, 64'd0, 1'b0};
    tbl[4]  = '{2,  1'b1, 64'h4444, 1'b0, 1, 64'h97, 2, 2'b10, 64'd0, 1'b0};
    tbl[5]  = '{50, 1'b1, 64'h5555, 1'b0, 1, 64'h96, 2, 2'b10, 64'd0, 1'b0};
    tbl[6]  = '{0,  1'b1, 64'h6666, 1'b0, 0, 64'h95, 17, 2'b01, 64'd0, 1'b1};
    tbl[7]  = '{0,  1'b1, 64'h7777, 1'b0, 15, 64'hCAFEF00D12345678, 17, 2'b00,
                64'hCAFEF00D12345678, 1'b1};
    tbl[8]  = '{33, 1'b0, 64'hA5A5A5A5A5A5A5A5, par_of(64'hA5A5A5A5A5A5A5A5), 2,
                64'h94, 4, 2'b00, 64'd0, 1'b1};
`ifdef TRI_SCOM_WDATA_PARITY_EN
    tbl[9]  = '{3,  1'b0, 64'h0000000000000001, 1'b0, 1, 64'h93, 2, 2'b10, 64'd0, 1'b0};
`else
    tbl[9]  = '{3,  1'b0, 64'h0000000000000001, 1'b0, 1, 64'h93, 3, 2'b00, 64'd0, 1'b1};
`endif
    tbl[10] = '{10, 1'b1, 64'h0000000000000003, 1'b1, 1, 64'h0F0F0F0F0F0F0F0F, 3, 2'b00,
                64'h0F0F0F0F0F0F0F0F, 1'b1};
    tbl[11] = '{2,  1'b0, 64'hBEEF, par_of(64'hBEEF), 16, 64'h92, 17, 2'b01, 64'd0, 1'b1};
    tbl[12] = '{3,  1'b1, 64'h8888, 1'b0, 14, 64'h8000000000000001, 16, 2'b00,
                64'h8000000000000001, 1'b1};
    tbl[13] = '{1,  1'b1, 64'h9999, 1'b0, 1, 64'h7, 3, 2'b00, 64'h7, 1'b1};

    // Reset state
    rst = 1'b1; sc_req = 1'b0; sc_addr = '0; sc_r_nw = 1'b0; sc_wdata = '0;
    sc_wdata_par = 1'b0; reg_ack = 1'b0; reg_rdata = '0;
    repeat (2) @(negedge nclk);
    chk("rst_busy", 64'(sc_busy), 64'd0);
    chk("rst_ack", 64'(sc_ack), 64'd0);
    chk("rst_info", 64'(sc_ack_info), 64'd0);
    chk("rst_rdata", sc_rdata, 64'd0);
    chk("rst_wr_en", 64'(reg_wr_en), 64'd0);
    chk("rst_rd_en", 64'(reg_rd_en), 64'd0);
    chk("rst_wdata", reg_wdata, 64'd0);
    rst = 1'b0;
    @(negedge nclk);

    // Directed vector table
    foreach (tbl[i]) begin
      run_txn(tbl[i].addr, tbl[i].r_nw, tbl[i].wd, tbl[i].par, tbl[i].ack_wc, tbl[i].rd,
              tbl[i].lat, tbl[i].info, tbl[i].exp_rd, tbl[i].ok, 1'b0);
    end

    // Read data holds while idle, then reset clears it
    run_txn(0, 1'b1, 64'h0, 1'b0, 1, 64'h0123_4567_89AB_CDEF, 3, 2'b00,
            64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    @(negedge nclk);
    chk("rdata_hold", sc_rdata, 64'h0123_4567_89AB_CDEF);
    rst = 1'b1;
    @(negedge nclk);
    rst = 1'b0;
    chk("rdata_rst_clear", sc_rdata, 64'd0);

    // Second request during WAIT is ignored; reset mid-WAIT aborts silently
    txn_id++;
    sc_req = 1'b1; sc_addr = 6'd0; sc_r_nw = 1'b1; sc_wdata = 64'h1234; sc_wdata_par = 1'b0;
    @(negedge nclk);
    sc_req = 1'b0;
    chk("abort_rd_strobe", 64'(reg_rd_en), 64'(48'h8000_0000_0000));
    @(negedge nclk);
    chk("abort_wait_busy", 64'(sc_busy), 64'd1);
    sc_req = 1'b1; sc_addr = 6'd33; sc_r_nw = 1'b0; sc_wdata = 64'hFFFF;
    sc_wdata_par = par_of(64'hFFFF);
    @(negedge nclk);
    sc_req = 1'b0;
    chk("second_req_busy", 64'(sc_busy), 64'd1);
    chk("second_req_wr_en", 64'(reg_wr_en), 64'd0);
    chk("second_req_wdata", reg_wdata, 64'h1234);
    rst = 1'b1;
    @(negedge nclk);
    rst = 1'b0;
    reg_ack = 1'b1; reg_rdata = '1;
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_busy", 64'(sc_busy), 64'd0);
      chk("post_rst_ack", 64'(sc_ack), 64'd0);
      chk("post_rst_strobe", 64'(reg_wr_en | reg_rd_en), 64'd0);
      chk("post_rst_rdata", sc_rdata, 64'd0);
      @(negedge nclk);
    end
    reg_ack = 1'b0;

    // Recovery after abort
    run_txn(tbl[0].addr, tbl[0].r_nw, tbl[0].wd, tbl[0].par, tbl[0].ack_wc, tbl[0].rd,
            tbl[0].lat, tbl[0].info, tbl[0].exp_rd, tbl[0].ok, 1'b0);

    // Randomized traffic with bus noise against the reference model
    for (int n = 0; n < 150; n++) begin
      addr   = ($urandom_range(0, 1) == 1) ? hot[$urandom_range(0, 5)] : int'($urandom_range(0, 63));
      r_nw   = 1'($urandom);
      wd     = {$urandom, $urandom};
      par    = par_of(wd) ^ ($urandom_range(0, 3) == 0);
      ack_wc = $urandom_range(0, 16);
      rd     = {$urandom, $urandom};
      model(addr, r_nw, wd, par, ack_wc, rd, lat, info, exp_rd, ok);
      run_txn(addr, r_nw, wd, par, ack_wc, rd, lat, info, exp_rd, ok, 1'b1);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        reg_ack = 1'($urandom);
        @(negedge nclk);
        chk("idle_busy", 64'(sc_busy), 64'd0);
      end
      reg_ack = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
